mult_share_arbiter: RTL and testbench

//  Shares one 4x4 pipelined multiplier (fixed MUL_LAT-cycle latency, one issue/cycle, no backpressure)

---
 rtl/mult_share_arbiter_if.sv | 30 +++
 rtl/mult_share_arbiter.sv | 110 +++++++++++
 tb/tb_mult_share_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// Bundle between the requesters, the shared-multiplier arbiter and the multiplier itself.
// The slave view is the arbiter; the master view drives requests and the multiplier return path.
interface mult_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic              arb_en;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_mult1;
  logic [4*NREQ-1:0] req_mult2;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_res;
  logic [2:0]        inflight;
  logic              err;
  logic              mul_data_rdy;
  logic [3:0]        mul_mult1;
  logic [3:0]        mul_mult2;
  logic              mul_res_rdy;
  logic [7:0]        mul_res;

  modport slave (
    input  arb_en, req_valid, req_mult1, req_mult2, mul_res_rdy, mul_res,
    output req_ready, rsp_valid, rsp_res, inflight, err, mul_data_rdy, mul_mult1, mul_mult2
  );

  modport master (
    output arb_en, req_valid, req_mult1, req_mult2, mul_res_rdy, mul_res,
    input  req_ready, rsp_valid, rsp_res, inflight, err, mul_data_rdy, mul_mult1, mul_mult2
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one fixed-latency 4x4 multiplier; a tag pipeline that mirrors the
// multiplier latency routes each product back to its issuer and cross-checks res_rdy.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 4,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  mult_share_arbiter_if.slave  bus
);

  localparam int OPW = 4;

  logic               win_found;
  logic [IDW-1:0]     win_id;
  logic [IDW-1:0]     scan_id;
  int                 scan_idx;
  logic               issue;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    rsp_vld;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]     tag_id_q [MUL_LAT];
  logic [2:0]         inflight_q, inflight_d;
  logic               err_q, err_d;
  logic               tail_vld;
  logic [IDW-1:0]     tail_id;

  // Arbitration: first valid requester at or after the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      scan_id = IDW'(scan_idx);
      if (!win_found && bus.req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // rstn is active-high; grants are masked while it is held so outputs clear immediately.
  assign issue = win_found & bus.arb_en & ~rstn;

  always_comb begin
    grant = '0;
    if (issue) grant[win_id] = 1'b1;
  end

  assign bus.req_ready    = grant;
  assign bus.mul_data_rdy = issue;
  assign bus.mul_mult1    = issue ? bus.req_mult1[win_id*OPW +: OPW] : '0;
  assign bus.mul_mult2    = issue ? bus.req_mult2[win_id*OPW +: OPW] : '0;

  assign tail_vld = tag_vld_q[MUL_LAT-1];
  assign tail_id  = tag_id_q[MUL_LAT-1];

  // Response: a mismatch between res_rdy and the tag tail suppresses every pulse.
  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_vld[i] = bus.mul_res_rdy & tail_vld & (tail_id == IDW'(i));
    end
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_res   = (|rsp_vld) ? bus.mul_res : 8'd0;
  assign bus.inflight  = inflight_q;
  assign bus.err       = err_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;

    inflight_d = inflight_q;
    if (issue && !tail_vld)      inflight_d = inflight_q + 3'd1;
    else if (!issue && tail_vld) inflight_d = inflight_q - 3'd1;

    err_d = err_q | (bus.mul_res_rdy != tail_vld);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      inflight_q <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= {tag_vld_q[MUL_LAT-2:0], issue};
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Tag ids are only meaningful alongside tag_vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= win_id;
    for (int s = 1; s < MUL_LAT; s++) begin
      tag_id_q[s] <= tag_id_q[s-1];
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural 4-cycle multiplier on the return path.
module tb_mult_share_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic force_rdy = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NREQ(NREQ)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Multiplier model: fixed latency, cleared by the same reset net.
  logic [MUL_LAT-1:0] m_rdy;
  logic [7:0]         m_res [MUL_LAT];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      m_rdy <= '0;
      for (int i = 0; i < MUL_LAT; i++) m_res[i] <= 8'd0;
    end else begin
      m_rdy    <= {m_rdy[MUL_LAT-2:0], bus.mul_data_rdy};
      m_res[0] <= 8'(bus.mul_mult1) * 8'(bus.mul_mult2);
      for (int i = 1; i < MUL_LAT; i++) m_res[i] <= m_res[i-1];
    end
  end

  assign bus.mul_res_rdy = m_rdy[MUL_LAT-1] | force_rdy;
  assign bus.mul_res     = m_res[MUL_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_mult1[4*i +: 4] = a;
    bus.req_mult2[4*i +: 4] = b;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    bus.req_valid = '0;
    repeat (2) cyc();
    rstn = 1'b0;
  endtask

  logic [3:0] t4_rdy [13] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] t4_rsp [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h0,
                              4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
  logic [7:0] t4_res [13] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd6, 8'd9, 8'd0,
                              8'd0, 8'd0, 8'd0, 8'd0, 8'd12};
  logic [2:0] t4_inf [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0,
                              3'd0, 3'd1, 3'd1, 3'd1, 3'd1};

  initial begin
    int id, iss, ret;
    bus.arb_en    = 1'b1;
    bus.req_valid = 4'h1;
    bus.req_mult1 = '0;
    bus.req_mult2 = '0;

    // Reset state, with a request pending that must not be granted.
    repeat (2) cyc();
    chk("rst_ready",    bus.req_ready, 0);
    chk("rst_datardy",  bus.mul_data_rdy, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_err",      bus.err, 0);
    chk("rst_rspvalid", bus.rsp_valid, 0);
    chk("rst_rspres",   bus.rsp_res, 0);

    // T1: single op 3*5.
    cyc();
    rstn = 1'b0;
    set_op(0, 4'd3, 4'd5);
    bus.req_valid = 4'h1;
    #1;
    chk("t1_ready", bus.req_ready, 4'h1);
    chk("t1_m1",    bus.mul_mult1, 3);
    chk("t1_m2",    bus.mul_mult2, 5);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      bus.req_valid = '0;
      #1;
      chk("t1_rspv", bus.rsp_valid, (c == 4) ? 4'h1 : 4'h0);
      chk("t1_res",  bus.rsp_res, (c == 4) ? 15 : 0);
      chk("t1_inf",  bus.inflight, (c <= 4) ? 1 : 0);
    end

    // T2: three requesters streaming from reset.
    do_reset();
    for (int i = 0; i < 3; i++) set_op(i, 4'(i + 1), 4'd2);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) cyc();
      bus.req_valid = (c < 12) ? 4'h7 : 4'h0;
      #1;
      chk("t2_ready", bus.req_ready, (c < 12) ? (4'h1 << (c % 3)) : 4'h0);
      id = (c - 4) % 3;
      chk("t2_rspv", bus.rsp_valid, (c >= 4 && c < 16) ? (4'h1 << id) : 4'h0);
      chk("t2_res",  bus.rsp_res, (c >= 4 && c < 16) ? (id + 1) * 2 : 0);
      iss = (c < 12) ? c : 12;
      ret = (c < 4) ? 0 : ((c - 4 < 12) ? c - 4 : 12);
      chk("t2_inf", bus.inflight, iss - ret);
    end

    // T3: maximum product, then a zero product from the same requester.
    cyc();
    set_op(3, 4'd15, 4'd15);
    bus.req_valid = 4'h8;
    #1;
    chk("t3_ready0", bus.req_ready, 4'h8);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) set_op(3, 4'd0, 4'd9);
      if (c == 2) bus.req_valid = '0;
      #1;
      if (c == 1) chk("t3_ready1", bus.req_ready, 4'h8);
      if (c >= 4) chk("t3_rspv", bus.rsp_valid, 4'h8);
      if (c == 4) chk("t3_res_max", bus.rsp_res, 225);
      if (c == 5) chk("t3_res_zero", bus.rsp_res, 0);
    end

    // T4: arb_en dropped with three ops in flight, then re-enabled.
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd3);
    for (int c = 0; c <= 12; c++) begin
      cyc();
      bus.arb_en    = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
      bus.req_valid = (c >= 9) ? 4'h0 : 4'hF;
      #1;
      chk("t4_ready", bus.req_ready, t4_rdy[c]);
      chk("t4_rspv",  bus.rsp_valid, t4_rsp[c]);
      chk("t4_res",   bus.rsp_res, t4_res[c]);
      chk("t4_inf",   bus.inflight, t4_inf[c]);
    end

    // T5: reset with three ops in flight.
    for (int c = 0; c < 3; c++) begin
      cyc();
      bus.req_valid = 4'hF;
      #1;
      chk("t5_ready", bus.req_ready, 4'h1 << c);
    end
    cyc();
    chk("t5_inf_pre", bus.inflight, 3);
    rstn = 1'b1;
    #1;
    chk("t5_inf",     bus.inflight, 0);
    chk("t5_ready_r", bus.req_ready, 0);
    chk("t5_datardy", bus.mul_data_rdy, 0);
    chk("t5_m1",      bus.mul_mult1, 0);
    chk("t5_rspv_r",  bus.rsp_valid, 0);
    chk("t5_res_r",   bus.rsp_res, 0);
    chk("t5_err_r",   bus.err, 0);
    repeat (2) cyc();
    rstn = 1'b0;
    bus.req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t5_norsp", bus.rsp_valid, 0);
      cyc();
    end
    bus.req_valid = 4'hA;
    #1;
    chk("t5_first", bus.req_ready, 4'h2);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      bus.req_valid = '0;
      #1;
      if (c == 4) chk("t5_rspv", bus.rsp_valid, 4'h2);
      if (c == 4) chk("t5_res",  bus.rsp_res, 6);
    end
    chk("t5_inf_end", bus.inflight, 0);
    chk("t5_err_end", bus.err, 0);

    // T6: spurious res_rdy with an empty tag pipeline.
    cyc();
    force_rdy = 1'b1;
    #1;
    chk("t6_rspv", bus.rsp_valid, 0);
    chk("t6_err0", bus.err, 0);
    cyc();
    force_rdy = 1'b0;
    #1;
    chk("t6_err1", bus.err, 1);
    repeat (3) cyc();
    chk("t6_sticky", bus.err, 1);
    chk("t6_rspv_after", bus.rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
